// File: rtl/usb_timer_pkg.sv
// usb_timer_pkg: shared types and default constants for the USB receive bit timer.
//   timer_state_e  : controller state (StIdle, StRun)
//   Def*           : default values for the usb_bit_timer parameters
package usb_timer_pkg;

  typedef enum logic {
    StIdle = 1'b0,
    StRun  = 1'b1
  } timer_state_e;

  localparam int unsigned DefClksPerBit  = 8;
  localparam int unsigned DefSamplePoint = 3;
  localparam int unsigned DefBitsPerWord = 8;

endpackage

// File: rtl/usb_mod_counter.sv
// usb_mod_counter: modulo-N up counter with synchronous clear and increment enable.
//   clk     : clock, rising edge
//   rst     : asynchronous active-high reset, count -> 0
//   clr_i   : synchronous clear, wins over inc_i
//   inc_i   : advance by one, wrapping from N-1 to 0
//   count_o : current count
//   wrap_o  : high while count_o == N-1 (the next increment wraps)
module usb_mod_counter #(
  parameter int unsigned N = 8,
  parameter int unsigned W = (N > 1) ? $clog2(N) : 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr_i,
  input  logic         inc_i,
  output logic [W-1:0] count_o,
  output logic         wrap_o
);

  localparam logic [W-1:0] MaxCount = W'(N - 1);

  logic [W-1:0] count_d, count_q;

  always_comb begin
    count_d = count_q;
    if (clr_i) begin
      count_d = '0;
    end else if (inc_i) begin
      count_d = (count_q == MaxCount) ? '0 : count_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o = count_q;
  assign wrap_o  = (count_q == MaxCount);

endmodule

// File: rtl/usb_bit_timer.sv
// usb_bit_timer: bit-timing generator for the USB receive path.
//   clk           : system clock, rising edge
//   rst           : asynchronous active-high reset, forces IDLE
//   enable        : 1 = run, 0 = return to idle and clear counters
//   resync        : one-cycle pulse, realigns bit phase to 0
//   stuff_bit     : sampled during sample_strobe; marks the current bit as stuffed
//   busy          : high while running
//   sample_strobe : mid-bit sample pulse (phase == SAMPLE_POINT)
//   shift_strobe  : end-of-bit shift enable, suppressed for stuffed bits
//   word_done     : coincides with the shift of the last bit of a word
//   bit_cnt       : bits shifted so far in the current word
module usb_bit_timer
  import usb_timer_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT  = DefClksPerBit,
  parameter int unsigned SAMPLE_POINT  = DefSamplePoint,
  parameter int unsigned BITS_PER_WORD = DefBitsPerWord
) (
  input  logic clk,
  input  logic rst,
  input  logic enable,
  input  logic resync,
  input  logic stuff_bit,
  output logic busy,
  output logic sample_strobe,
  output logic shift_strobe,
  output logic word_done,
  output logic [((BITS_PER_WORD > 1) ? $clog2(BITS_PER_WORD) : 1)-1:0] bit_cnt
);

  localparam int unsigned PhaseW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int unsigned CntW   = (BITS_PER_WORD > 1) ? $clog2(BITS_PER_WORD) : 1;
  localparam logic [PhaseW-1:0] SamplePhase = PhaseW'(SAMPLE_POINT);

  if (CLKS_PER_BIT < 2) begin : g_bad_clks_per_bit
    $error("usb_bit_timer: CLKS_PER_BIT must be >= 2");
  end
  if (SAMPLE_POINT > CLKS_PER_BIT - 2) begin : g_bad_sample_point
    $error("usb_bit_timer: SAMPLE_POINT must be <= CLKS_PER_BIT-2");
  end
  if (BITS_PER_WORD < 1) begin : g_bad_bits_per_word
    $error("usb_bit_timer: BITS_PER_WORD must be >= 1");
  end

  timer_state_e state_d, state_q;
  logic         skip_d, skip_q;
  logic         run;
  logic [PhaseW-1:0] phase;
  logic         phase_wrap;
  logic         bit_wrap;
  logic         phase_clr;
  logic         bit_clr;

  assign run = (state_q == StRun);

  // Leaving RUN (or sitting in IDLE) clears everything; resync only realigns the phase.
  assign phase_clr = !run || !enable || resync;
  assign bit_clr   = !run || !enable;

  usb_mod_counter #(
    .N(CLKS_PER_BIT),
    .W(PhaseW)
  ) u_phase_cnt (
    .clk    (clk),
    .rst    (rst),
    .clr_i  (phase_clr),
    .inc_i  (run),
    .count_o(phase),
    .wrap_o (phase_wrap)
  );

  usb_mod_counter #(
    .N(BITS_PER_WORD),
    .W(CntW)
  ) u_bit_cnt (
    .clk    (clk),
    .rst    (rst),
    .clr_i  (bit_clr),
    .inc_i  (shift_strobe),
    .count_o(bit_cnt),
    .wrap_o (bit_wrap)
  );

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (enable) state_d = StRun;
      StRun:   if (!enable) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Sample phase never equals the wrap phase, so set and clear cannot collide.
  always_comb begin
    skip_d = skip_q;
    if (phase_clr || phase_wrap) begin
      skip_d = 1'b0;
    end else if (sample_strobe && stuff_bit) begin
      skip_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      skip_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      skip_q  <= skip_d;
    end
  end

  assign busy          = run;
  assign sample_strobe = run && (phase == SamplePhase);
  assign shift_strobe  = run && phase_wrap && !skip_q;
  assign word_done     = shift_strobe && bit_wrap;

endmodule

// File: doc/usb_bit_timer.md
# usb_bit_timer

Parametrised bit-timing generator for the USB receive path. Divides the system clock into bit periods of `CLKS_PER_BIT` cycles and pulses a mid-bit sample strobe and an end-of-bit shift strobe. It re-aligns its bit phase on every line transition, suppresses the shift for stuffed bits, and counts bits into words. It sits between the edge detector / bit-unstuffer and the receive shift register, and drives that register's shift enable.

## Interface
- `CLKS_PER_BIT`, default 8: clocks per bit period; must be ≥ 2.
- `SAMPLE_POINT`, default 3: phase value at which the sample strobe fires; must satisfy 0 ≤ value ≤ `CLKS_PER_BIT`-2.
- `BITS_PER_WORD`, default 8: shifted bits per word; must be ≥ 1.
- `clk`  in  1  system clock; all state changes on the rising edge.
- `rst`  in  1  reset; asynchronous, active-high, forces IDLE.
- `enable`  in  1  run request; high = RUN, low = return to IDLE.
- `resync`  in  1  one-cycle pulse from the edge detector; realigns the bit phase.
- `stuff_bit`  in  1  from the unstuffer; when high during a sample-strobe cycle, the current bit is a stuffed bit.
- `busy`  out  1  high while in RUN.
- `sample_strobe`  out  1  one-cycle pulse at the mid-bit sample point.
- `shift_strobe`  out  1  one-cycle pulse at end of bit; this is the shift enable for the receive shift register.
- `word_done`  out  1  one-cycle pulse, coincident with the shift of the last bit of a word.
- `bit_cnt`  out  $clog2(`BITS_PER_WORD`) (minimum 1)  count of bits shifted in the current word.

## Operation
- **States:** IDLE and RUN. The state encoding lives in the package.
- **IDLE:**
  - phase = 0, bit_cnt = 0, skip flag = 0.
  - All strobes are low.
  - `resync` and `stuff_bit` are ignored.
  - `enable`=1 moves to RUN with phase = 0.
- **RUN, phase counter:**
  - Phase advances by 1 every cycle.
  - Phase wraps from `CLKS_PER_BIT`-1 to 0.
- **RUN, resync:**
  - `resync`=1 loads phase = 0 on the next edge. This takes priority over increment and wrap.
  - The skip flag is cleared.
  - bit_cnt is unchanged.
- **RUN, enable dropped:**
  - `enable`=0 moves to IDLE on the next edge and clears all counters. This takes priority over resync.
- **Strobe decode:** all strobes are Moore decodes of registered state, so they never depend combinationally on inputs.
  - `sample_strobe` = RUN && phase == `SAMPLE_POINT`.
  - `shift_strobe` = RUN && phase == `CLKS_PER_BIT`-1 && !skip.
  - `word_done` = `shift_strobe` && bit_cnt == `BITS_PER_WORD`-1.
- **Stuffed-bit handling:**
  - skip is set at the edge that closes a `sample_strobe` cycle in which `stuff_bit`=1.
  - skip is cleared at the phase wrap.
  - A skipped bit produces no `shift_strobe` and does not advance bit_cnt.
- **Bit counting:** bit_cnt increments on each `shift_strobe` and wraps to 0 at the `word_done` shift.
- **Resync inside a bit:** a resync before the end-of-bit phase discards the partial bit, i.e. no shift is issued for it.

## Timing
- **Reset values:** `busy`, `sample_strobe`, `shift_strobe` and `word_done` are 0; `bit_cnt` is 0. These hold while `rst`=1 regardless of `clk`.
- **Start-up latency:** `enable` is sampled high at edge E0. `busy` rises after E0.
  - First `sample_strobe` occupies the cycle after edge E0+`SAMPLE_POINT`.
  - First `shift_strobe` occupies the cycle after edge E0+`CLKS_PER_BIT`-1.
- **Steady state:** strobes repeat every `CLKS_PER_BIT` cycles.
- **Resync timing:** `resync` sampled at edge R gives phase 0 after R.
  - Next `sample_strobe` is `SAMPLE_POINT` cycles later.
  - A strobe already high in the resync cycle still completes.
- **Simultaneous resync and wrap:** the result is phase 0 either way, with no extra strobe.
- **Reset mid-operation:** all outputs drop asynchronously. Restart obeys the start-up latency above.

## Structure
- Package `usb_timer_pkg` holds:
  - the state enum (IDLE, RUN);
  - default constants for `CLKS_PER_BIT`, `SAMPLE_POINT` and `BITS_PER_WORD`.
- Sub-module `usb_mod_counter`: a generic modulo-N counter with synchronous clear, increment enable and wrap flag, with `rst` active-high async.
  - It is instantiated twice, once for the phase counter and once for the bit counter.
- Elaboration-time assertions check the parameter legality rules listed under Interface.

## Test plan
- **Reset:** defaults; assert `rst` mid-RUN → all outputs 0 within the same cycle; after release, restart gives the first `sample_strobe` 4 cycles after `enable` is sampled.
- **Free run:** `enable` held 1, no resync, no stuffing.
  - `sample_strobe` at phase 3 and `shift_strobe` at phase 7, period 8 cycles.
  - `word_done` on the 8th `shift_strobe`, 64 cycles after start; `bit_cnt` steps 0→7→0.
- **Resync:**
  - Pulse `resync` at phase 5 → phase 0 next cycle; next `sample_strobe` 3 cycles later; no `shift_strobe` for the discarded partial bit; `bit_cnt` unchanged.
  - Pulse `resync` during the phase-7 `shift_strobe` cycle → that strobe still fires and `bit_cnt` advances.
- **Stuffed bit:** `stuff_bit`=1 during the 3rd `sample_strobe` → no 3rd-bit `shift_strobe`, `bit_cnt` holds at 2, and `word_done` slips by one bit period to 72 cycles.
- **Disable:** drop `enable` at phase 2 of bit 4 → `busy`=0 next cycle; `bit_cnt`=0; no further strobes; re-enable restarts at bit 0.
- **Parameter sweep:** (`CLKS_PER_BIT`, `SAMPLE_POINT`, `BITS_PER_WORD`) ∈ {(2,0,1), (4,1,8), (40,19,16)} → strobe period, sample offset and `word_done` spacing match the formulas above.
